// File: rtl/pes_add_tree.sv
// pes_add_tree: three-stage pipelined 8-input unsigned adder tree.
//   Stage 1 registers four lane sums, stage 2 two partial sums, stage 3 the
//   grand total. Every output comes straight from a flop and is full width,
//   so no sum can wrap.
// Ports:
//   clk          clock, all state updates on rising edge
//   rst          asynchronous active-low reset, clears all outputs
//   a0..a3       8-bit first operands, lanes 0..3
//   b0..b3       8-bit second operands, lanes 0..3
//   y0..y3       9-bit registered lane sums, yN = aN + bN
//   y4, y5       10-bit registered partial sums, y0 + y1 and y2 + y3
//   y            11-bit registered grand total, y4 + y5
module pes_add_tree (
  output logic [10:0] y,
  output logic [8:0]  y0,
  output logic [8:0]  y1,
  output logic [8:0]  y2,
  output logic [8:0]  y3,
  output logic [9:0]  y4,
  output logic [9:0]  y5,
  input  logic [7:0]  a0,
  input  logic [7:0]  a1,
  input  logic [7:0]  a2,
  input  logic [7:0]  a3,
  input  logic [7:0]  b0,
  input  logic [7:0]  b1,
  input  logic [7:0]  b2,
  input  logic [7:0]  b3,
  input  logic        rst,
  input  logic        clk
);

  // Stage 1: lane sums, operands zero-extended to keep the carry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y0 <= '0;
      y1 <= '0;
      y2 <= '0;
      y3 <= '0;
    end else begin
      y0 <= {1'b0, a0} + {1'b0, b0};
      y1 <= {1'b0, a1} + {1'b0, b1};
      y2 <= {1'b0, a2} + {1'b0, b2};
      y3 <= {1'b0, a3} + {1'b0, b3};
    end
  end

  // Stage 2: partial sums of the current stage-1 registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y4 <= '0;
      y5 <= '0;
    end else begin
      y4 <= {1'b0, y0} + {1'b0, y1};
      y5 <= {1'b0, y2} + {1'b0, y3};
    end
  end

  // Stage 3: grand total of the current stage-2 registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y <= '0;
    end else begin
      y <= {1'b0, y4} + {1'b0, y5};
    end
  end

endmodule

// File: tb/tb_pes_add_tree.sv
// Directed self-checking bench for pes_add_tree. Inputs change and outputs
// are sampled on the falling clock edge, away from the active rising edge.
module tb_pes_add_tree;

  logic        clk;
  logic        rst;
  logic [7:0]  a0, a1, a2, a3, b0, b1, b2, b3;
  logic [10:0] y;
  logic [8:0]  y0, y1, y2, y3;
  logic [9:0]  y4, y5;

  int unsigned n_cmp;
  int unsigned n_err;

  pes_add_tree dut (
    .y  (y),
    .y0 (y0),
    .y1 (y1),
    .y2 (y2),
    .y3 (y3),
    .y4 (y4),
    .y5 (y5),
    .a0 (a0),
    .a1 (a1),
    .a2 (a2),
    .a3 (a3),
    .b0 (b0),
    .b1 (b1),
    .b2 (b2),
    .b3 (b3),
    .rst(rst),
    .clk(clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run is short, this only guards against a stuck simulation.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int unsigned va0, input int unsigned va1,
                       input int unsigned va2, input int unsigned va3,
                       input int unsigned vb0, input int unsigned vb1,
                       input int unsigned vb2, input int unsigned vb3);
    a0 = va0[7:0]; a1 = va1[7:0]; a2 = va2[7:0]; a3 = va3[7:0];
    b0 = vb0[7:0]; b1 = vb1[7:0]; b2 = vb2[7:0]; b3 = vb3[7:0];
  endtask

  task automatic check_all(input string tag,
                           input int e0, input int e1, input int e2, input int e3,
                           input int e4, input int e5, input int ey);
    check({tag, ".y0"}, int'(y0), e0);
    check({tag, ".y1"}, int'(y1), e1);
    check({tag, ".y2"}, int'(y2), e2);
    check({tag, ".y3"}, int'(y3), e3);
    check({tag, ".y4"}, int'(y4), e4);
    check({tag, ".y5"}, int'(y5), e5);
    check({tag, ".y"},  int'(y),  ey);
  endtask

  // Advance one full cycle; returns just after the next falling edge.
  task automatic cycle();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    drive(8'hA5, 8'h3C, 8'hFF, 8'h01, 8'h77, 8'h80, 8'h12, 8'hEE);

    // Reset hold with a running clock and non-zero inputs.
    repeat (3) cycle();
    check_all("rst_hold", 0, 0, 0, 0, 0, 0, 0);

    // Nominal vector, released on a falling edge; check 1/2/3-edge latency.
    drive(1, 5, 9, 13, 3, 7, 11, 15);
    rst = 1'b1;
    cycle();
    check_all("nom_e1", 4, 12, 20, 28, 0, 0, 0);
    cycle();
    check_all("nom_e2", 4, 12, 20, 28, 16, 48, 0);
    cycle();
    check_all("nom_e3", 4, 12, 20, 28, 16, 48, 64);

    // Maximum operands: widest representable sums at every stage.
    drive(255, 255, 255, 255, 255, 255, 255, 255);
    repeat (3) cycle();
    check_all("max", 510, 510, 510, 510, 1020, 1020, 2040);

    // Streaming: all-1s then all-2s on consecutive edges, then all-3s.
    drive(1, 1, 1, 1, 1, 1, 1, 1);
    cycle();
    drive(2, 2, 2, 2, 2, 2, 2, 2);
    cycle();
    drive(3, 3, 3, 3, 3, 3, 3, 3);
    check("stream.y4_first", int'(y4), 4);
    cycle();
    check("stream.y_first", int'(y), 8);
    check("stream.y4_second", int'(y4), 8);
    cycle();
    check("stream.y_second", int'(y), 16);
    cycle();
    check("stream.y_third", int'(y), 24);

    // Mid-stream asynchronous reset, asserted between clock edges.
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
    cycle();
    check_all("rst_held", 0, 0, 0, 0, 0, 0, 0);
    drive(1, 5, 9, 13, 3, 7, 11, 15);
    rst = 1'b1;
    cycle();
    check_all("rel_e1", 4, 12, 20, 28, 0, 0, 0);
    cycle();
    check_all("rel_e2", 4, 12, 20, 28, 16, 48, 0);
    cycle();
    check_all("rel_e3", 4, 12, 20, 28, 16, 48, 64);

    // Asymmetric lane: only a3 non-zero.
    drive(0, 0, 0, 200, 0, 0, 0, 0);
    repeat (3) cycle();
    check_all("asym", 0, 0, 0, 200, 0, 200, 200);

    // Asymmetric left half, exercising y4 without y5.
    drive(100, 0, 0, 0, 0, 27, 0, 0);
    repeat (3) cycle();
    check_all("asym_left", 100, 27, 0, 0, 127, 0, 127);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
